// File: rtl/mult_host_if.sv
// Initiator-side sequencer for the sequential multiplier controller: accepts operands,
// launches the controller, retries on controller error, and returns product or error.
module mult_host_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned TIMEOUT   = 8,
    parameter int unsigned MAX_RETRY = 1
) (
    input  logic               clk,
    input  logic               reset_a,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]   mult_a,
    output logic [WIDTH-1:0]   mult_b,
    output logic               start,
    input  logic               done,
    input  logic [2:0]         mult_state,
    input  logic [2*WIDTH-1:0] product,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_product,
    output logic               rsp_err,
    output logic               rsp_retried
);

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam int unsigned RW = $clog2(MAX_RETRY + 1) + 1;
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] MaxRetry    = RW'(MAX_RETRY);
    localparam logic [2:0]    CtrlErr     = 3'b101;

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

    state_e             r_state;
    logic [WIDTH-1:0]   r_mult_a;
    logic [WIDTH-1:0]   r_mult_b;
    logic [2*WIDTH-1:0] r_rsp_product;
    logic               r_rsp_err;
    logic               r_rsp_retried;
    logic [TW-1:0]      r_timer;
    logic [RW-1:0]      r_retry;

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            r_state       <= StIdle;
            r_mult_a      <= '0;
            r_mult_b      <= '0;
            r_rsp_product <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_retried <= 1'b0;
            r_timer       <= '0;
            r_retry       <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_mult_a      <= req_a;
                        r_mult_b      <= req_b;
                        r_retry       <= '0;
                        r_rsp_retried <= 1'b0;
                        r_state       <= StLaunch;
                    end
                end
                StLaunch: begin
                    r_timer <= '0;
                    r_state <= StWait;
                end
                StWait: begin
                    // done outranks a controller error, which outranks the timeout
                    if (done) begin
                        r_rsp_product <= product;
                        r_rsp_err     <= 1'b0;
                        r_state       <= StResp;
                    end else if (mult_state == CtrlErr) begin
                        if (r_retry < MaxRetry) begin
                            r_retry       <= r_retry + 1'b1;
                            r_rsp_retried <= 1'b1;
                            r_state       <= StLaunch;
                        end else begin
                            r_rsp_product <= '0;
                            r_rsp_err     <= 1'b1;
                            r_state       <= StResp;
                        end
                    end else if (r_timer == TimeoutLast) begin
                        r_rsp_product <= '0;
                        r_rsp_err     <= 1'b1;
                        r_state       <= StResp;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign req_ready   = (r_state == StIdle);
    assign start       = (r_state == StLaunch);
    assign rsp_valid   = (r_state == StResp);
    assign mult_a      = r_mult_a;
    assign mult_b      = r_mult_b;
    assign rsp_product = r_rsp_product;
    assign rsp_err     = r_rsp_err;
    assign rsp_retried = r_rsp_retried;

endmodule

// File: tb/tb_mult_host_if.sv
// Bench for mult_host_if: a behavioural multiplier-controller model plus directed and random
// operations, each checked against latencies and results computed from the controller timing.
module tb_mult_host_if;

    localparam int W         = 8;
    localparam int TIMEOUT   = 8;
    localparam int MAX_RETRY = 1;
    localparam int DONE_DLY  = 5;   // controller raises done this many cycles after start
    localparam int ERR_DLY   = 2;   // controller error appears this many cycles after start

    logic           clk = 1'b0;
    logic           reset_a;
    logic           req_valid;
    logic           req_ready;
    logic [W-1:0]   req_a;
    logic [W-1:0]   req_b;
    logic [W-1:0]   mult_a;
    logic [W-1:0]   mult_b;
    logic           start;
    logic           done;
    logic [2:0]     mult_state;
    logic [2*W-1:0] product;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*W-1:0] rsp_product;
    logic           rsp_err;
    logic           rsp_retried;

    int total = 0;
    int bad   = 0;

    mult_host_if #(
        .WIDTH     (W),
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk         (clk),
        .reset_a     (reset_a),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .start       (start),
        .done        (done),
        .mult_state  (mult_state),
        .product     (product),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_err     (rsp_err),
        .rsp_retried (rsp_retried)
    );

    always #5 clk = ~clk;

    // Controller model. Modes: 0 healthy, 1 error on first launch only, 2 always error,
    // 3 never finishes.
    int       mode = 0;
    int       op_base = 0;
    int       launches;
    int       nth;
    logic     active;
    logic [3:0] k;

    always @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            active   <= 1'b0;
            k        <= '0;
            launches <= 0;
        end else if (start) begin
            active   <= 1'b1;
            k        <= 4'd1;
            launches <= launches + 1;
        end else if (active && k != 4'hF) begin
            k <= k + 4'd1;
        end
    end

    assign nth  = launches - op_base;
    assign done = active && (32'(k) == DONE_DLY) && (mode == 0 || (mode == 1 && nth >= 2));
    assign mult_state = (active && 32'(k) >= ERR_DLY && (mode == 2 || (mode == 1 && nth == 1)))
                        ? 3'b101 : 3'b001;
    assign product = done ? (16'(mult_a) * 16'(mult_b)) : 16'hBEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle index (accept-edge cycle = 0) at which rsp_valid is first high.
    function automatic int exp_rsp_cyc(input int m);
        case (m)
            0:       return DONE_DLY + 1;
            1:       return (ERR_DLY + 1) + (DONE_DLY + 1);
            2:       return MAX_RETRY * (ERR_DLY + 1) + (ERR_DLY + 1);
            default: return TIMEOUT + 1;
        endcase
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int m,
                         input int hold);
        int   nst;
        int   rcyc;
        logic moved;
        logic unstable;
        logic exp_err;
        logic [31:0] exp_prod;
        mode    = m;
        op_base = launches;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        nst   = 0;
        rcyc  = -1;
        moved = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) req_valid = 1'b0;
            if (start) nst++;
            if (mult_a !== a || mult_b !== b) moved = 1'b1;
            if (rsp_valid) begin
                rcyc = c;
                break;
            end
        end
        exp_err  = (m == 2 || m == 3);
        exp_prod = exp_err ? 32'd0 : 32'(a) * 32'(b);
        chk("rsp_latency", rcyc, exp_rsp_cyc(m));
        chk("start_pulses", nst, (m == 1) ? 2 : (m == 2) ? MAX_RETRY + 1 : 1);
        chk("operands_held", 32'(moved), 32'd0);
        chk("rsp_product", 32'(rsp_product), exp_prod);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("rsp_retried", 32'(rsp_retried), 32'(m == 1 || (m == 2 && MAX_RETRY > 0)));
        unstable = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!rsp_valid || req_ready || start || 32'(rsp_product) !== exp_prod
                || rsp_err !== exp_err) unstable = 1'b1;
        end
        if (hold > 0) chk("resp_held", 32'(unstable), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_consumed", 32'(rsp_valid), 32'd0);
        chk("req_ready_after", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic quiet;
        reset_a   = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_start", 32'(start), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset_a = 1'b1;

        do_op(8'd13, 8'd11, 0, 0);      // basic: 143
        do_op(8'd255, 8'd255, 0, 10);   // backpressure: FE01 held
        do_op(8'd6, 8'd7, 1, 1);        // one relaunch then 42
        do_op(8'($urandom), 8'($urandom), 2, 2);  // retries exhausted
        do_op(8'($urandom), 8'($urandom), 3, 0);  // timeout

        // Reset while waiting on the controller.
        mode    = 0;
        op_base = launches;
        @(negedge clk);
        req_a     = 8'd200;
        req_b     = 8'd9;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_a = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_start", 32'(start), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_mult_ab", 32'({mult_a, mult_b}), 32'd0);
        chk("mid_rst_rsp", 32'({rsp_product, rsp_err, rsp_retried}), 32'd0);
        @(negedge clk);
        reset_a = 1'b1;
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid || start) quiet = 1'b0;
        end
        chk("no_aborted_rsp", 32'(quiet), 32'd1);
        do_op(8'd3, 8'd4, 0, 0);

        for (int i = 0; i < 8; i++) begin
            do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
